// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - state/snoop encodings and the per-line coherence transition function
package coherence_pkg;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_M = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;
  localparam logic [1:0] ST_E = 2'b11;

  localparam logic [1:0] SNP_READ_MISS  = 2'b00;
  localparam logic [1:0] SNP_WRITE_MISS = 2'b01;
  localparam logic [1:0] SNP_INVALIDATE = 2'b10;
  localparam logic [1:0] SNP_RSVD       = 2'b11;

  typedef enum logic [1:0] {FSM_IDLE, FSM_LOOKUP, FSM_WB, FSM_RESP} fsm_t;

  typedef struct packed {
    logic [1:0] state;
    logic       wb;
    logic       abort;
    logic       shared;
  } snp_result_t;

  // Result for a line already known to match the snooped tag.
  // A stray E with MESI disabled cannot be legitimately held, so it is ignored.
  function automatic snp_result_t next_state(input logic [1:0] state,
                                             input logic [1:0] snp_type,
                                             input logic       mesi_en);
    snp_result_t r;
    r = '{state: state, wb: 1'b0, abort: 1'b0, shared: 1'b0};
    if (state != ST_I && snp_type != SNP_RSVD && (mesi_en || state != ST_E)) begin
      r.shared = 1'b1;
      r.state  = (snp_type == SNP_READ_MISS) ? ST_S : ST_I;
      if (state == ST_M && snp_type != SNP_INVALIDATE) begin
        r.wb    = 1'b1;
        r.abort = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/coherence_state_array.sv
// rtl/coherence_state_array.sv - direct-mapped tag/state storage, reset to I
module coherence_state_array
  import coherence_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [1:0]       upd_state,
  input  logic             st_en,
  input  logic [IDX_W-1:0] st_index,
  input  logic [1:0]       st_state,
  input  logic [IDX_W-1:0] rd_index,
  output logic [TAG_W-1:0] rd_tag,
  output logic [1:0]       rd_state,
  input  logic [IDX_W-1:0] lk_index,
  output logic [TAG_W-1:0] lk_tag,
  output logic [1:0]       lk_state
);

  logic [TAG_W-1:0] tag_q   [NUM_LINES];
  logic [1:0]       state_q [NUM_LINES];

  // The snoop state write only ever targets a line the update port is locked out of.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= ST_I;
      end
    end else begin
      if (upd_en) begin
        tag_q[upd_index]   <= upd_tag;
        state_q[upd_index] <= upd_state;
      end
      if (st_en) begin
        state_q[st_index] <= st_state;
      end
    end
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_state = state_q[rd_index];
  assign lk_tag   = tag_q[lk_index];
  assign lk_state = state_q[lk_index];

endmodule

// File: rtl/snoop_coherence_controller.sv
// rtl/snoop_coherence_controller.sv - snoop handler: lookup, MSI/MESI transition, write-back, response
module snoop_coherence_controller
  import coherence_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_LINES = 64,
  parameter int OFFSET_W  = 4,
  parameter bit MESI_EN   = 1'b1,
  localparam int IDX_W    = $clog2(NUM_LINES),
  localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [1:0]        snp_type,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_resp_valid,
  output logic              snp_resp_abort,
  output logic              snp_resp_shared,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic [1:0]        upd_state,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [1:0]        rd_state,
  output logic [TAG_W-1:0]  rd_tag
);

  localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  fsm_t              fsm_q, fsm_n;
  logic [1:0]        cap_type;
  logic [ADDR_W-1:0] cap_addr;
  snp_result_t       res_q, res_n;
  logic              hit_q, hit_n;
  logic [TAG_W-1:0]  lk_tag;
  logic [1:0]        lk_state;
  logic [IDX_W-1:0]  cap_idx;
  logic [TAG_W-1:0]  cap_tag;
  logic              upd_en;
  logic [1:0]        upd_state_eff;

  assign cap_idx = cap_addr[OFFSET_W +: IDX_W];
  assign cap_tag = cap_addr[ADDR_W-1 -: TAG_W];
  assign wb_addr = cap_addr;

  assign upd_en        = upd_valid && upd_ready;
  assign upd_state_eff = (!MESI_EN && upd_state == ST_E) ? ST_S : upd_state;

  coherence_state_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd_en   (upd_en),
    .upd_index(upd_index),
    .upd_tag  (upd_tag),
    .upd_state(upd_state_eff),
    .st_en    (fsm_q == FSM_RESP && hit_q),
    .st_index (cap_idx),
    .st_state (res_q.state),
    .rd_index (rd_index),
    .rd_tag   (rd_tag),
    .rd_state (rd_state),
    .lk_index (cap_idx),
    .lk_tag   (lk_tag),
    .lk_state (lk_state)
  );

  always_comb begin
    hit_n = (lk_state != ST_I) && (lk_tag == cap_tag);
    res_n = hit_n ? next_state(lk_state, cap_type, MESI_EN)
                  : '{state: lk_state, wb: 1'b0, abort: 1'b0, shared: 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= FSM_IDLE;
    end else begin
      fsm_q <= fsm_n;
    end
  end

  always_comb begin
    fsm_n = fsm_q;
    case (fsm_q)
      FSM_IDLE:   if (snp_valid) fsm_n = FSM_LOOKUP;
      FSM_LOOKUP: fsm_n = res_n.wb ? FSM_WB : FSM_RESP;
      FSM_WB:     if (wb_ready) fsm_n = FSM_RESP;
      FSM_RESP:   fsm_n = FSM_IDLE;
      default:    fsm_n = FSM_IDLE;
    endcase
  end

  always_comb begin
    snp_ready       = rst_n && (fsm_q == FSM_IDLE);
    wb_valid        = rst_n && (fsm_q == FSM_WB);
    snp_resp_valid  = rst_n && (fsm_q == FSM_RESP);
    snp_resp_abort  = snp_resp_valid && res_q.abort;
    snp_resp_shared = snp_resp_valid && res_q.shared;
    upd_ready       = rst_n && ((fsm_q == FSM_IDLE) || (upd_index != cap_idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_type <= SNP_READ_MISS;
      cap_addr <= '0;
      res_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      if (fsm_q == FSM_IDLE && snp_valid) begin
        cap_type <= snp_type;
        cap_addr <= snp_addr & BLOCK_MASK;
      end
      if (fsm_q == FSM_LOOKUP) begin
        res_q <= res_n;
        hit_q <= hit_n;
      end
    end
  end

endmodule
